// File: rtl/ysyx_25020077_ctrl_fsm.sv
// rtl/ysyx_25020077_ctrl_fsm.sv - multi-cycle fetch/decode/memory/writeback sequencer
//
// Owns the PC and instruction registers and sequences one instruction at a time.
// Ports:
//   clock, reset (async, active-low)
//   io_ifu_req_valid/ready, io_ifu_resp_valid/data   instruction fetch handshake
//   io_lsu_req_valid/ready/wen, io_lsu_resp_valid     load/store handshake
//   io_next_pc                                         PC computed by the datapath
//   io_pc, io_inst, io_imm_type, io_rf_wen             datapath controls
//   io_halt, io_illegal, io_state                      status / debug
module ysyx_25020077_ctrl_fsm #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        io_ifu_req_valid,
   input  logic        io_ifu_req_ready,
   input  logic        io_ifu_resp_valid,
   input  logic [31:0] io_ifu_resp_data,
   output logic        io_lsu_req_valid,
   input  logic        io_lsu_req_ready,
   output logic        io_lsu_req_wen,
   input  logic        io_lsu_resp_valid,
   input  logic [31:0] io_next_pc,
   output logic [31:0] io_pc,
   output logic [31:0] io_inst,
   output logic [2:0]  io_imm_type,
   output logic        io_rf_wen,
   output logic        io_halt,
   output logic        io_illegal,
   output logic [2:0]  io_state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_WAIT_I = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WAIT_M = 3'd5,
      S_WB     = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        illegal_q;

   logic [6:0] opcode;
   logic       is_load;
   logic       is_store;
   logic       is_legal;
   logic       is_ebreak;
   logic       writes_rd;

   assign opcode    = inst_q[6:0];
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_ebreak = (inst_q == EBREAK);

   // SYSTEM is deliberately absent: only the exact ebreak encoding is accepted.
   assign is_legal  = is_load || is_store || (opcode == OP_IMM) || (opcode == OP_OP) ||
                      (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                      (opcode == OP_JALR) || (opcode == OP_BRANCH);

   assign writes_rd = is_load || (opcode == OP_IMM) || (opcode == OP_OP) ||
                      (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                      (opcode == OP_JALR);

   // State and architectural registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_FETCH;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_WAIT_I && io_ifu_resp_valid) begin
            inst_q <= io_ifu_resp_data;
         end
         if (state == S_WB) begin
            pc_q <= io_next_pc;
         end
         if (state == S_DECODE && !is_ebreak && !is_legal) begin
            illegal_q <= 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_FETCH:  if (io_ifu_req_ready)  state_nxt = S_WAIT_I;
         S_WAIT_I: if (io_ifu_resp_valid) state_nxt = S_DECODE;
         S_DECODE: begin
            if (is_ebreak || !is_legal) state_nxt = S_HALT;
            else                        state_nxt = S_EXEC;
         end
         S_EXEC:   state_nxt = (is_load || is_store) ? S_MEM : S_WB;
         S_MEM:    if (io_lsu_req_ready)  state_nxt = S_WAIT_M;
         S_WAIT_M: if (io_lsu_resp_valid) state_nxt = S_WB;
         S_WB:     state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // Outputs decoded from state and the instruction register
   always_comb begin
      io_ifu_req_valid = (state == S_FETCH);
      io_lsu_req_valid = (state == S_MEM);
      io_lsu_req_wen   = (state == S_MEM) && is_store;
      io_rf_wen        = (state == S_WB) && writes_rd;
      io_halt          = (state == S_HALT);
      io_illegal       = illegal_q;
      io_state         = state;
      io_pc            = pc_q;
      io_inst          = inst_q;

      io_imm_type = 3'd0;
      unique case (opcode)
         OP_IMM, OP_JALR, OP_LOAD: io_imm_type = 3'd1;
         OP_STORE:                 io_imm_type = 3'd2;
         OP_LUI, OP_AUIPC:         io_imm_type = 3'd3;
         OP_JAL:                   io_imm_type = 3'd4;
         OP_BRANCH:                io_imm_type = 3'd5;
         default:                  io_imm_type = 3'd0;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25020077_ctrl_fsm.sv
// tb/tb_ysyx_25020077_ctrl_fsm.sv - scoreboard bench for ysyx_25020077_ctrl_fsm
module tb_ysyx_25020077_ctrl_fsm;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        io_ifu_req_valid;
   logic        io_ifu_req_ready = 1'b1;
   logic        io_ifu_resp_valid = 1'b0;
   logic [31:0] io_ifu_resp_data = 32'h0;
   logic        io_lsu_req_valid;
   logic        io_lsu_req_ready = 1'b0;
   logic        io_lsu_req_wen;
   logic        io_lsu_resp_valid = 1'b0;
   logic [31:0] io_next_pc = 32'h0;
   logic [31:0] io_pc;
   logic [31:0] io_inst;
   logic [2:0]  io_imm_type;
   logic        io_rf_wen;
   logic        io_halt;
   logic        io_illegal;
   logic [2:0]  io_state;

   ysyx_25020077_ctrl_fsm #(.RESET_PC(RST_PC)) dut (
      .clock             (clock),
      .reset             (reset),
      .io_ifu_req_valid  (io_ifu_req_valid),
      .io_ifu_req_ready  (io_ifu_req_ready),
      .io_ifu_resp_valid (io_ifu_resp_valid),
      .io_ifu_resp_data  (io_ifu_resp_data),
      .io_lsu_req_valid  (io_lsu_req_valid),
      .io_lsu_req_ready  (io_lsu_req_ready),
      .io_lsu_req_wen    (io_lsu_req_wen),
      .io_lsu_resp_valid (io_lsu_resp_valid),
      .io_next_pc        (io_next_pc),
      .io_pc             (io_pc),
      .io_inst           (io_inst),
      .io_imm_type       (io_imm_type),
      .io_rf_wen         (io_rf_wen),
      .io_halt           (io_halt),
      .io_illegal        (io_illegal),
      .io_state          (io_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc_after;
      logic [2:0]  imm;
      logic        rf;
      int          lat;      // cycle index of WB, or of first HALT cycle
      int          lsu_cyc;  // cycles with lsu_req_valid high
      logic        wen;
      logic        halt;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc_after,
                               input logic [2:0] imm, input logic rf, input int lat,
                               input int lsu_cyc, input logic wen, input logic halt,
                               input logic ill);
      exp_t e;
      e.inst = inst; e.pc_after = pc_after; e.imm = imm; e.rf = rf; e.lat = lat;
      e.lsu_cyc = lsu_cyc; e.wen = wen; e.halt = halt; e.ill = ill;
      return e;
   endfunction

   // Monitor: measures each instruction from its FETCH cycle and scores it at WB/HALT.
   initial begin : monitor
      exp_t        e;
      int          cyc = 0;
      int          rf_cnt = 0;
      int          rf_cyc = 0;
      int          lsu_cnt = 0;
      logic        wen_seen = 1'b0;
      logic [2:0]  imm_seen = 3'd0;
      logic [2:0]  prev = 3'd7;
      logic        pc_pend = 1'b0;
      logic [31:0] pc_exp = 32'h0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev    = 3'd7;
            pc_pend = 1'b0;
         end else begin
            if (io_state == 3'd0 && prev != 3'd0) begin
               cyc = 1; rf_cnt = 0; lsu_cnt = 0; wen_seen = 1'b0; imm_seen = 3'd0;
               if (pc_pend) begin
                  chk($sformatf("pc_after_%h", pc_exp), io_pc, pc_exp);
                  pc_pend = 1'b0;
               end
            end else begin
               cyc++;
            end
            if (io_rf_wen) begin rf_cnt++; rf_cyc = cyc; end
            if (io_lsu_req_valid) begin lsu_cnt++; wen_seen = wen_seen | io_lsu_req_wen; end
            if (io_state == 3'd2) imm_seen = io_imm_type;
            if (io_state == 3'd6 || (io_state == 3'd7 && prev != 3'd7)) begin
               if (sb.size() == 0) begin
                  chk("sb_underflow", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("imm_%h", e.inst), 32'(imm_seen), 32'(e.imm));
                  chk($sformatf("lat_%h", e.inst), 32'(cyc), 32'(e.lat));
                  chk($sformatf("rf_cnt_%h", e.inst), 32'(rf_cnt), e.rf ? 32'd1 : 32'd0);
                  if (e.rf) chk($sformatf("rf_cyc_%h", e.inst), 32'(rf_cyc), 32'(e.lat));
                  chk($sformatf("lsu_cyc_%h", e.inst), 32'(lsu_cnt), 32'(e.lsu_cyc));
                  chk($sformatf("lsu_wen_%h", e.inst), 32'(wen_seen), 32'(e.wen));
                  chk($sformatf("halt_%h", e.inst), 32'(io_halt), 32'(e.halt));
                  chk($sformatf("illegal_%h", e.inst), 32'(io_illegal), 32'(e.ill));
                  if (io_state == 3'd6) begin
                     pc_exp  = e.pc_after;
                     pc_pend = 1'b1;
                  end
               end
            end
            prev = io_state;
         end
      end
   end

   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      chk({tag, "_state"}, 32'(io_state), 32'd0);
      chk({tag, "_pc"}, io_pc, RST_PC);
      chk({tag, "_inst"}, io_inst, 32'd0);
      chk({tag, "_ifu_valid"}, 32'(io_ifu_req_valid), 32'd1);
      chk({tag, "_lsu_valid"}, 32'(io_lsu_req_valid), 32'd0);
      chk({tag, "_lsu_wen"}, 32'(io_lsu_req_wen), 32'd0);
      chk({tag, "_rf_wen"}, 32'(io_rf_wen), 32'd0);
      chk({tag, "_halt"}, 32'(io_halt), 32'd0);
      chk({tag, "_illegal"}, 32'(io_illegal), 32'd0);
      chk({tag, "_imm"}, 32'(io_imm_type), 32'd0);
      @(posedge clock);
      #2;
      reset = 1'b1;
   endtask

   // Handshake the fetch and return one cycle later with the instruction.
   task automatic do_fetch(input logic [31:0] inst);
      int n = 0;
      while (!io_ifu_req_valid && n < 50) begin @(negedge clock); n++; end
      if (n >= 50) chk("fetch_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
      io_ifu_resp_valid = 1'b1;
      io_ifu_resp_data  = inst;
      @(posedge clock); #1;
      io_ifu_resp_valid = 1'b0;
      io_ifu_resp_data  = 32'hDEAD_BEEF;
   endtask

   task automatic wait_lsu_valid();
      int n = 0;
      do begin @(negedge clock); n++; end while (!io_lsu_req_valid && n < 50);
      if (n >= 50) chk("lsu_req_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_inst(input exp_t e, input int rdy_wait, input int rsp_wait);
      int n = 0;
      io_next_pc = e.pc_after;
      sb.push_back(e);
      do_fetch(e.inst);
      if (e.lsu_cyc > 0) begin
         wait_lsu_valid();
         for (int i = 0; i < rdy_wait; i++) begin @(posedge clock); #1; end
         io_lsu_req_ready = 1'b1;
         @(posedge clock); #1;
         io_lsu_req_ready = 1'b0;
         for (int i = 0; i < rsp_wait; i++) begin @(posedge clock); #1; end
         io_lsu_resp_valid = 1'b1;
         @(posedge clock); #1;
         io_lsu_resp_valid = 1'b0;
      end
      do begin @(negedge clock); n++; end while (io_state != 3'd0 && io_state != 3'd7 && n < 60);
      if (n >= 60) chk($sformatf("done_timeout_%h", e.inst), 32'd0, 32'd1);
      if (io_state == 3'd7) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("halt_no_fetch_%h", e.inst), 32'(io_ifu_req_valid), 32'd0);
            chk($sformatf("halt_state_%h", e.inst), 32'(io_state), 32'd7);
            chk($sformatf("halt_ill_hold_%h", e.inst), 32'(io_illegal), 32'(e.ill));
         end
         do_reset($sformatf("rst_after_%h", e.inst));
      end
   endtask

   initial begin
      #3;
      do_reset("rst0");
      //                 inst          pc_after      imm  rf lat lsu wen halt ill
      run_inst(mk(32'h0010_0093, 32'h8000_0004, 3'd1, 1, 5,  0, 0, 0, 0), 0, 0); // addi
      run_inst(mk(32'h0020_A023, 32'h8000_0008, 3'd2, 0, 10, 4, 1, 0, 0), 3, 0); // sw
      run_inst(mk(32'h0000_A103, 32'h8000_000C, 3'd1, 1, 9,  1, 0, 0, 0), 0, 2); // lw
      run_inst(mk(32'h0020_81B3, 32'h8000_0010, 3'd0, 1, 5,  0, 0, 0, 0), 0, 0); // add
      run_inst(mk(32'h1234_5237, 32'h8000_0014, 3'd3, 1, 5,  0, 0, 0, 0), 0, 0); // lui
      run_inst(mk(32'h0000_0297, 32'h8000_0018, 3'd3, 1, 5,  0, 0, 0, 0), 0, 0); // auipc
      run_inst(mk(32'h0080_00EF, 32'h8000_0040, 3'd4, 1, 5,  0, 0, 0, 0), 0, 0); // jal
      run_inst(mk(32'h0000_80E7, 32'h8000_0080, 3'd1, 1, 5,  0, 0, 0, 0), 0, 0); // jalr
      run_inst(mk(32'h0020_8463, 32'h8000_0100, 3'd5, 0, 5,  0, 0, 0, 0), 0, 0); // beq
      run_inst(mk(32'h0000_2003, 32'h8000_0104, 3'd1, 1, 7,  1, 0, 0, 0), 0, 0); // lw, min latency

      // Reset while a load request is pending in MEM; a late response must be ignored.
      io_next_pc = 32'h8000_0200;
      do_fetch(32'h0000_A103);
      wait_lsu_valid();
      io_lsu_req_ready = 1'b1;
      #2;
      do_reset("rst_mem");
      io_lsu_req_ready  = 1'b0;
      io_lsu_resp_valid = 1'b1;
      run_inst(mk(32'h0010_0093, 32'h8000_0004, 3'd1, 1, 5,  0, 0, 0, 0), 0, 0);
      io_lsu_resp_valid = 1'b0;

      run_inst(mk(32'h0010_0073, 32'h0,         3'd0, 0, 4,  0, 0, 1, 0), 0, 0); // ebreak
      run_inst(mk(32'h0000_0073, 32'h0,         3'd0, 0, 4,  0, 0, 1, 1), 0, 0); // ecall
      run_inst(mk(32'h0000_000F, 32'h0,         3'd0, 0, 4,  0, 0, 1, 1), 0, 0); // fence
      run_inst(mk(32'hFFFF_FFFF, 32'h0,         3'd0, 0, 4,  0, 0, 1, 1), 0, 0); // illegal
      run_inst(mk(32'h0010_0093, 32'h8000_0004, 3'd1, 1, 5,  0, 0, 0, 0), 0, 0); // addi after halt

      repeat (2) @(negedge clock);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
